// File: rtl/data_fwd_buffer.sv
// data_fwd_buffer
//   Pending-write buffer that sits in front of a cache. Writes are queued in
//   a circular FIFO and drained to the cache in issue order. Reads are checked
//   against every pending entry. The youngest matching entry is forwarded.
//   If nothing matches, the read returns the cache's combinational read data.
//   A small state machine records the dependency class between the last two
//   accepted read/write operations.
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   op_valid/op_type/op_addr/
//   op_wdata/op_ready             operation request (00 RD, 01 WR, else NOOP)
//   rd_valid/rd_data/read_from    registered read result (1-cycle latency)
//   hazard_state                  000 RAR, 001 RAW, 010 WAR, 011 WAW, 100 INIT
//   occupancy                     number of pending entries
//   cache_rd_data                 cache data for op_addr, same cycle
//   cache_wr_valid/ready/addr/data  drain handshake presenting the head entry
//
// Hazard state machine
//   state  | meaning
//   INIT   | no RD/WR accepted since reset
//   RAR    | last accepted op RD, previous one RD (or first op)
//   RAW    | last accepted op RD, previous one WR
//   WAR    | last accepted op WR, previous one RD
//   WAW    | last accepted op WR, previous one WR (or first op)
module data_fwd_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    input  logic [1:0]               op_type,
    input  logic [ADDR_W-1:0]        op_addr,
    input  logic [DATA_W-1:0]        op_wdata,
    output logic                     op_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     read_from,
    output logic [2:0]               hazard_state,
    output logic [$clog2(DEPTH):0]   occupancy,
    input  logic [DATA_W-1:0]        cache_rd_data,
    output logic                     cache_wr_valid,
    input  logic                     cache_wr_ready,
    output logic [ADDR_W-1:0]        cache_wr_addr,
    output logic [DATA_W-1:0]        cache_wr_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        HZ_RAR  = 3'b000,
        HZ_RAW  = 3'b001,
        HZ_WAR  = 3'b010,
        HZ_WAW  = 3'b011,
        HZ_INIT = 3'b100
    } hz_t;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    hz_t               hz_q;
    hz_t               hz_d;

    logic              accept;
    logic              rd_en;
    logic              wr_en;
    logic              retire;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

    // Ready depends only on registered occupancy, so a retire on a full
    // cycle frees space only from the following cycle.
    assign op_ready       = (count != CNT_W'(DEPTH));
    assign accept         = op_valid && op_ready;
    assign rd_en          = accept && (op_type == 2'b00);
    assign wr_en          = accept && (op_type == 2'b01);
    assign cache_wr_valid = (count != '0);
    assign retire         = cache_wr_valid && cache_wr_ready;
    assign cache_wr_addr  = mem_addr[head];
    assign cache_wr_data  = mem_data[head];
    assign occupancy      = count;
    assign hazard_state   = hz_q;

    // Walk from oldest to youngest, so the last match found is the youngest.
    // The head stays searchable in the cycle it retires because the entry
    // storage has not changed yet.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = cache_rd_data;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (mem_addr[idx] == op_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[idx];
            end
        end
    end

    // Entry storage needs no reset: validity is defined by head and count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_addr[tail] <= op_addr;
            mem_data[tail] <= op_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                tail <= tail + 1'b1;
            end
            if (retire) begin
                head <= head + 1'b1;
            end
            if (wr_en && !retire) begin
                count <= count + 1'b1;
            end else if (retire && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            read_from <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data   <= fwd_data;
                read_from <= fwd_hit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hz_q <= HZ_INIT;
        end else begin
            hz_q <= hz_d;
        end
    end

    // The previous op was a WR exactly when the current class ends in WR
    // (WAR/WAW); INIT behaves like "previous was RD" for a RD and like
    // "previous was WR" for a WR.
    always_comb begin
        hz_d = hz_q;
        if (rd_en) begin
            hz_d = (hz_q == HZ_WAR || hz_q == HZ_WAW) ? HZ_RAW : HZ_RAR;
        end else if (wr_en) begin
            hz_d = (hz_q == HZ_RAR || hz_q == HZ_RAW) ? HZ_WAR : HZ_WAW;
        end
    end

endmodule
